// File: rtl/rgmii_link_speed_ctrl.sv
// rtl/rgmii_link_speed_ctrl.sv - MDIO link-status poller driving RGMII speed, link state and MAC reset
module rgmii_link_speed_ctrl #(
    parameter logic [4:0] PHY_ADDR      = 5'd0,
    parameter logic [4:0] STATUS_REG    = 5'h11,
    parameter int         MDC_DIV       = 20,
    parameter int         POLL_INTERVAL = 1000000,
    parameter int         RST_HOLD      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       mdc,
    output logic       mdio_o,
    output logic       mdio_oe,
    input  logic       mdio_i,
    output logic [1:0] speed,
    output logic       link_up,
    output logic       duplex,
    output logic       speed_update,
    output logic       mac_rst,
    output logic       rd_error,
    output logic       busy
);

    localparam int PW = $clog2(MDC_DIV);
    localparam int TW = $clog2(POLL_INTERVAL + 1);
    localparam int HW = $clog2(RST_HOLD + 1);

    localparam logic [PW-1:0] PHASE_LAST = PW'(MDC_DIV - 1);
    localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
    localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_INTERVAL);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD - 1);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

    // Driven frame bits 0..45 (preamble, ST, OP=read, PHYAD, REGAD); the
    // trailing 18 ones make bit b of the frame simply TX_BITS[63-b], and
    // give the idle-high level during TA and data.
    localparam logic [63:0] TX_BITS = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, STATUS_REG, 18'h3FFFF};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_EVAL  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [5:0]    r_bit;
    logic [5:0]    w_bit_nxt;
    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_nxt;
    logic          r_half;
    logic          w_half_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;

    logic          r_rx_ta;
    logic [1:0]    r_rx_spd;
    logic          r_rx_dup;
    logic          r_rx_res;
    logic          r_rx_lnk;

    logic          r_mdc;
    logic          r_mdio_o;
    logic          r_mdio_oe;
    logic [1:0]    r_speed;
    logic          r_link_up;
    logic          r_duplex;
    logic          r_speed_update;
    logic          r_mac_rst;
    logic          r_rd_error;
    logic          r_busy;

    logic          w_sample_pt;
    logic          w_reject;
    logic          w_link_ok;
    logic          w_change;
    logic          w_drive_nxt;

    // The PHY has had a full MDC low phase to present the bit by the last low cycle.
    assign w_sample_pt = (r_state == ST_FRAME) && !r_half && (r_phase == PHASE_LAST);
    assign w_reject    = r_rx_ta || (r_rx_spd == 2'b11);
    assign w_link_ok   = r_rx_res && r_rx_lnk;
    assign w_change    = !r_link_up || (r_rx_spd != r_speed) || (r_rx_dup != r_duplex);
    assign w_drive_nxt = (w_state_nxt == ST_FRAME) && (w_bit_nxt < 6'd46);

    // Next-state and counter logic for poll timing, MDC bit timing and reset hold.
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_phase_nxt = r_phase;
        w_half_nxt  = r_half;
        w_timer_nxt = r_timer;
        w_hold_nxt  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    if (r_timer >= POLL_LAST) begin
                        w_state_nxt = ST_FRAME;
                        w_timer_nxt = '0;
                        w_bit_nxt   = 6'd0;
                        w_phase_nxt = '0;
                        w_half_nxt  = 1'b0;
                    end else begin
                        w_timer_nxt = r_timer + TIMER_ONE;
                    end
                end
            end
            ST_FRAME: begin
                if (r_phase == PHASE_LAST) begin
                    w_phase_nxt = '0;
                    if (r_half) begin
                        w_half_nxt = 1'b0;
                        if (r_bit == 6'd63) begin
                            w_state_nxt = ST_EVAL;
                        end else begin
                            w_bit_nxt = r_bit + 6'd1;
                        end
                    end else begin
                        w_half_nxt = 1'b1;
                    end
                end else begin
                    w_phase_nxt = r_phase + PHASE_ONE;
                end
            end
            ST_EVAL: begin
                if (!w_reject && w_link_ok && w_change) begin
                    w_state_nxt = ST_HOLD;
                    w_hold_nxt  = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (enable && (r_timer < POLL_LAST)) begin
                    w_timer_nxt = r_timer + TIMER_ONE;
                end
                if (r_hold == HOLD_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hold_nxt = r_hold + HOLD_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; the poll timer starts full so the first frame goes out immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_bit   <= 6'd0;
            r_phase <= '0;
            r_half  <= 1'b0;
            r_timer <= POLL_LAST;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            r_phase <= w_phase_nxt;
            r_half  <= w_half_nxt;
            r_timer <= w_timer_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // MDIO pins registered from next-state values so they move only at bit and half-bit boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdc     <= 1'b0;
            r_mdio_o  <= 1'b1;
            r_mdio_oe <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_mdc     <= (w_state_nxt == ST_FRAME) && w_half_nxt;
            r_mdio_oe <= w_drive_nxt;
            r_mdio_o  <= w_drive_nxt ? TX_BITS[6'd63 - w_bit_nxt] : 1'b1;
            r_busy    <= (w_state_nxt == ST_FRAME) || (w_state_nxt == ST_EVAL);
        end
    end

    // Capture TA and the status fields that matter; the rest of the data phase is clocked but ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ta  <= 1'b0;
            r_rx_spd <= 2'b00;
            r_rx_dup <= 1'b0;
            r_rx_res <= 1'b0;
            r_rx_lnk <= 1'b0;
        end else if (w_sample_pt) begin
            case (r_bit)
                6'd47:   r_rx_ta     <= mdio_i;
                6'd48:   r_rx_spd[1] <= mdio_i;
                6'd49:   r_rx_spd[0] <= mdio_i;
                6'd50:   r_rx_dup    <= mdio_i;
                6'd52:   r_rx_res    <= mdio_i;
                6'd53:   r_rx_lnk    <= mdio_i;
                default: ;
            endcase
        end
    end

    // Link outputs: evaluate the read result, and keep the MAC in reset while down or settling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_speed        <= 2'b10;
            r_link_up      <= 1'b0;
            r_duplex       <= 1'b0;
            r_mac_rst      <= 1'b1;
            r_speed_update <= 1'b0;
            r_rd_error     <= 1'b0;
        end else begin
            r_speed_update <= 1'b0;
            r_rd_error     <= 1'b0;
            if (r_state == ST_EVAL) begin
                if (w_reject) begin
                    r_rd_error <= 1'b1;
                end else if (!w_link_ok) begin
                    r_link_up <= 1'b0;
                    r_mac_rst <= 1'b1;
                end else if (w_change) begin
                    r_speed        <= r_rx_spd;
                    r_duplex       <= r_rx_dup;
                    r_link_up      <= 1'b1;
                    r_speed_update <= 1'b1;
                    r_mac_rst      <= 1'b1;
                end
            end else if ((r_state == ST_HOLD) && (r_hold == HOLD_LAST)) begin
                r_mac_rst <= 1'b0;
            end
        end
    end

    assign mdc          = r_mdc;
    assign mdio_o       = r_mdio_o;
    assign mdio_oe      = r_mdio_oe;
    assign speed        = r_speed;
    assign link_up      = r_link_up;
    assign duplex       = r_duplex;
    assign speed_update = r_speed_update;
    assign mac_rst      = r_mac_rst;
    assign rd_error     = r_rd_error;
    assign busy         = r_busy;

endmodule

// File: tb/tb_rgmii_link_speed_ctrl.sv
// tb/tb_rgmii_link_speed_ctrl.sv - directed self-checking bench for rgmii_link_speed_ctrl
module tb_rgmii_link_speed_ctrl;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       mdc;
    logic       mdio_o;
    logic       mdio_oe;
    logic       mdio_i;
    logic [1:0] speed;
    logic       link_up;
    logic       duplex;
    logic       speed_update;
    logic       mac_rst;
    logic       rd_error;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    // Driven part of the frame for PHY_ADDR=3, STATUS_REG=0x11: 32x1, 01, 10, 00011, 10001.
    localparam logic [45:0] EXP_TX = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'b00011, 5'b10001};

    rgmii_link_speed_ctrl #(
        .PHY_ADDR      (5'h03),
        .STATUS_REG    (5'h11),
        .MDC_DIV       (2),
        .POLL_INTERVAL (40),
        .RST_HOLD      (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mdc          (mdc),
        .mdio_o       (mdio_o),
        .mdio_oe      (mdio_oe),
        .mdio_i       (mdio_i),
        .speed        (speed),
        .link_up      (link_up),
        .duplex       (duplex),
        .speed_update (speed_update),
        .mac_rst      (mac_rst),
        .rd_error     (rd_error),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_speed"}, 64'(speed), 64'(2'b10));
        chk({pfx, "_link_up"}, 64'(link_up), 64'd0);
        chk({pfx, "_duplex"}, 64'(duplex), 64'd0);
        chk({pfx, "_mac_rst"}, 64'(mac_rst), 64'd1);
        chk({pfx, "_speed_update"}, 64'(speed_update), 64'd0);
        chk({pfx, "_rd_error"}, 64'(rd_error), 64'd0);
        chk({pfx, "_busy"}, 64'(busy), 64'd0);
        chk({pfx, "_mdc"}, 64'(mdc), 64'd0);
        chk({pfx, "_mdio_o"}, 64'(mdio_o), 64'd1);
        chk({pfx, "_mdio_oe"}, 64'(mdio_oe), 64'd0);
    endtask

    // Plays the PHY for one frame; returns at the negedge of the EVAL cycle,
    // or at the third cycle of stop_bit when stop_bit >= 0.
    task automatic run_frame(input logic [15:0] data, input logic ta, input int drop_bit,
                             input int stop_bit, output int waited);
        logic [63:0] obs_o;
        logic [63:0] obs_oe;
        int          mdc_bad;
        waited  = 0;
        mdc_bad = 0;
        obs_o   = '0;
        obs_oe  = '0;
        while (busy !== 1'b1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        chk("frame_start", 64'(busy), 64'd1);
        if (busy !== 1'b1) return;
        for (int b = 0; b < 64; b++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) begin
                    if (b == drop_bit) enable = 1'b0;
                    mdio_i = (b == 47) ? ta : (b >= 48) ? data[63-b] : 1'b1;
                    obs_o[63-b]  = mdio_o;
                    obs_oe[63-b] = mdio_oe;
                end
                if (mdc !== (c >= 2)) mdc_bad++;
                if (b == stop_bit && c == 2) return;
                @(negedge clk);
            end
        end
        mdio_i = 1'b1;
        chk("frame_tx_bits", obs_o, {EXP_TX, 18'h3FFFF});
        chk("frame_oe_bits", obs_oe, {46'h3FFF_FFFF_FFFF, 18'h0});
        chk("frame_mdc_bad", 64'(mdc_bad), 64'd0);
        chk("eval_busy", 64'(busy), 64'd1);
        chk("eval_mdc", 64'(mdc), 64'd0);
        chk("eval_oe", 64'(mdio_oe), 64'd0);
    endtask

    task automatic expect_update(input logic [1:0] spd, input logic dup);
        int n;
        @(negedge clk);
        chk("upd_speed", 64'(speed), 64'(spd));
        chk("upd_duplex", 64'(duplex), 64'(dup));
        chk("upd_link_up", 64'(link_up), 64'd1);
        chk("upd_pulse", 64'(speed_update), 64'd1);
        chk("upd_mac_rst", 64'(mac_rst), 64'd1);
        chk("upd_busy", 64'(busy), 64'd0);
        n = 0;
        while (mac_rst === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            if (n == 1) chk("upd_pulse_width", 64'(speed_update), 64'd0);
        end
        chk("hold_cycles", 64'(n), 64'd16);
        chk("hold_speed_kept", 64'(speed), 64'(spd));
    endtask

    task automatic expect_nochange(input logic [1:0] spd);
        @(negedge clk);
        chk("same_pulse", 64'(speed_update), 64'd0);
        chk("same_rd_error", 64'(rd_error), 64'd0);
        chk("same_link_up", 64'(link_up), 64'd1);
        chk("same_mac_rst", 64'(mac_rst), 64'd0);
        chk("same_speed", 64'(speed), 64'(spd));
        repeat (20) @(negedge clk);
        chk("same_mac_rst_later", 64'(mac_rst), 64'd0);
    endtask

    task automatic expect_reject(input logic [1:0] spd);
        @(negedge clk);
        chk("rej_rd_error", 64'(rd_error), 64'd1);
        chk("rej_link_up", 64'(link_up), 64'd1);
        chk("rej_mac_rst", 64'(mac_rst), 64'd0);
        chk("rej_speed", 64'(speed), 64'(spd));
        chk("rej_pulse", 64'(speed_update), 64'd0);
        @(negedge clk);
        chk("rej_rd_error_width", 64'(rd_error), 64'd0);
    endtask

    initial begin
        int w;
        int busy_cnt;
        rst_n  = 1'b0;
        enable = 1'b0;
        mdio_i = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("rst");

        // Enable together with reset release: the frame must start at the very next edge.
        enable = 1'b1;
        rst_n  = 1'b1;
        run_frame(16'hAC00, 1'b0, -1, -1, w);
        chk("first_start_latency", 64'(w), 64'd1);
        expect_update(2'b10, 1'b1);

        run_frame(16'h6C00, 1'b0, -1, -1, w);
        expect_update(2'b01, 1'b1);

        run_frame(16'h6C00, 1'b0, -1, -1, w);
        expect_nochange(2'b01);

        run_frame(16'h2000, 1'b0, -1, -1, w);
        @(negedge clk);
        chk("down_link_up", 64'(link_up), 64'd0);
        chk("down_mac_rst", 64'(mac_rst), 64'd1);
        chk("down_speed", 64'(speed), 64'(2'b01));
        chk("down_duplex", 64'(duplex), 64'd1);
        chk("down_pulse", 64'(speed_update), 64'd0);

        run_frame(16'h6C00, 1'b0, -1, -1, w);
        expect_update(2'b01, 1'b1);

        run_frame(16'h6C00, 1'b1, -1, -1, w);
        expect_reject(2'b01);

        run_frame(16'hEC00, 1'b0, -1, -1, w);
        expect_reject(2'b01);

        // Enable dropped mid-frame: frame finishes and is evaluated, then polling stops.
        run_frame(16'hAC00, 1'b0, 20, -1, w);
        expect_update(2'b10, 1'b1);
        busy_cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
        end
        chk("disabled_no_frame", 64'(busy_cnt), 64'd0);

        // Async reset in the middle of the data phase, during an MDC high phase.
        enable = 1'b1;
        run_frame(16'h6C00, 1'b0, -1, 50, w);
        chk("pre_rst_mdc", 64'(mdc), 64'd1);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
